// File: rtl/pwu_req_sched.sv
// rtl/pwu_req_sched.sv - round-robin scheduler sharing one PWU translation port
// Issue register feeds the PWU; an in-order tag queue routes each PA back to its requester.

module pwu_req_sched_tagq #(
    parameter int TAG_W = 2,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  logic [TAG_W-1:0]           push_tag_i,
    input  logic                       pop_i,
    output logic [TAG_W-1:0]           head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= push_tag_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;
endmodule

module pwu_req_sched #(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = 8,
    parameter int VA_W    = 32,
    parameter int PA_W    = 28
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [NUM_REQ*VA_W-1:0]    req_va_i,
    input  logic [NUM_REQ-1:0]         req_vld_i,
    output logic [NUM_REQ-1:0]         req_rdy_o,
    output logic [PA_W-1:0]            resp_pa_o,
    output logic                       resp_fault_o,
    output logic [NUM_REQ-1:0]         resp_vld_o,
    input  logic [NUM_REQ-1:0]         resp_rdy_i,
    output logic [VA_W-1:0]            pwu_va_o,
    output logic                       pwu_va_vld_o,
    input  logic                       pwu_va_rdy_i,
    input  logic [PA_W-1:0]            pwu_pa_i,
    input  logic                       pwu_pa_vld_i,
    input  logic                       pwu_pa_fault_i,
    output logic                       pwu_pa_rdy_o,
    output logic [$clog2(DEPTH+1)-1:0] inflight_o,
    output logic                       orphan_err_o
);
    localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [TAG_W-1:0] LAST_C  = TAG_W'(NUM_REQ-1);
    localparam logic [TAG_W:0]   NREQ_C  = (TAG_W+1)'(NUM_REQ);

    logic             iss_vld_q, iss_vld_d;
    logic [VA_W-1:0]  iss_va_q, iss_va_d;
    logic [TAG_W-1:0] rr_q, rr_d;
    logic             orphan_q, orphan_d;

    logic [TAG_W-1:0] head_tag;
    logic [CNT_W-1:0] count;
    logic [TAG_W-1:0] gnt_idx;
    logic             gnt_any;
    logic [TAG_W:0]   cand_sum;
    logic [TAG_W-1:0] cand;
    logic [VA_W-1:0]  gnt_va;
    logic             free, can_issue, push, pop, nonempty;

    // Round-robin search starting at rr, wrapping modulo NUM_REQ.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        cand_sum = '0;
        cand     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_sum = {1'b0, rr_q} + (TAG_W+1)'(i);
            if (cand_sum >= NREQ_C) cand_sum = cand_sum - NREQ_C;
            cand = cand_sum[TAG_W-1:0];
            if (!gnt_any && req_vld_i[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        gnt_va = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (gnt_idx == TAG_W'(r)) gnt_va = req_va_i[r*VA_W +: VA_W];
        end
    end

    // Registered count only: a same-cycle pop never opens a grant slot.
    assign free      = !iss_vld_q || pwu_va_rdy_i;
    assign can_issue = free && (count < DEPTH_C) && !reset_i;
    assign push      = can_issue && gnt_any;
    assign nonempty  = (count != '0);
    assign pop       = pwu_pa_vld_i && pwu_pa_rdy_o;

    always_comb begin
        req_rdy_o  = '0;
        resp_vld_o = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            req_rdy_o[r]  = push && (gnt_idx == TAG_W'(r));
            resp_vld_o[r] = pwu_pa_vld_i && nonempty && !reset_i && (head_tag == TAG_W'(r));
        end
    end

    assign pwu_pa_rdy_o = nonempty && !reset_i && resp_rdy_i[head_tag];
    assign resp_pa_o    = pwu_pa_i;
    assign resp_fault_o = pwu_pa_fault_i;
    assign pwu_va_o     = iss_va_q;
    assign pwu_va_vld_o = iss_vld_q;
    assign inflight_o   = count;
    assign orphan_err_o = orphan_q;

    always_comb begin
        iss_vld_d = iss_vld_q;
        iss_va_d  = iss_va_q;
        rr_d      = rr_q;
        orphan_d  = orphan_q || (pwu_pa_vld_i && !nonempty);
        if (push) begin
            iss_vld_d = 1'b1;
            iss_va_d  = gnt_va;
            rr_d      = (gnt_idx == LAST_C) ? '0 : gnt_idx + TAG_W'(1);
        end else if (pwu_va_rdy_i) begin
            iss_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            iss_vld_q <= 1'b0;
            iss_va_q  <= '0;
            rr_q      <= '0;
            orphan_q  <= 1'b0;
        end else begin
            iss_vld_q <= iss_vld_d;
            iss_va_q  <= iss_va_d;
            rr_q      <= rr_d;
            orphan_q  <= orphan_d;
        end
    end

    pwu_req_sched_tagq #(
        .TAG_W (TAG_W),
        .DEPTH (DEPTH)
    ) u_tagq (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .push_i     (push),
        .push_tag_i (gnt_idx),
        .pop_i      (pop),
        .head_o     (head_tag),
        .count_o    (count)
    );
endmodule

// File: tb/tb_pwu_req_sched.sv
// tb/tb_pwu_req_sched.sv - self-checking bench for pwu_req_sched
// Queue-based reference model plus directed literal expectations and random traffic.

module tb_pwu_req_sched;
    localparam int NR = 4;
    localparam int D  = 8;
    localparam int VW = 32;
    localparam int PW = 28;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_i;
    logic [NR*VW-1:0] req_va_i;
    logic [NR-1:0]   req_vld_i;
    logic [NR-1:0]   req_rdy_o;
    logic [PW-1:0]   resp_pa_o;
    logic            resp_fault_o;
    logic [NR-1:0]   resp_vld_o;
    logic [NR-1:0]   resp_rdy_i;
    logic [VW-1:0]   pwu_va_o;
    logic            pwu_va_vld_o;
    logic            pwu_va_rdy_i;
    logic [PW-1:0]   pwu_pa_i;
    logic            pwu_pa_vld_i;
    logic            pwu_pa_fault_i;
    logic            pwu_pa_rdy_o;
    logic [3:0]      inflight_o;
    logic            orphan_err_o;

    pwu_req_sched #(.NUM_REQ(NR), .DEPTH(D), .VA_W(VW), .PA_W(PW)) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .req_va_i       (req_va_i),
        .req_vld_i      (req_vld_i),
        .req_rdy_o      (req_rdy_o),
        .resp_pa_o      (resp_pa_o),
        .resp_fault_o   (resp_fault_o),
        .resp_vld_o     (resp_vld_o),
        .resp_rdy_i     (resp_rdy_i),
        .pwu_va_o       (pwu_va_o),
        .pwu_va_vld_o   (pwu_va_vld_o),
        .pwu_va_rdy_i   (pwu_va_rdy_i),
        .pwu_pa_i       (pwu_pa_i),
        .pwu_pa_vld_i   (pwu_pa_vld_i),
        .pwu_pa_fault_i (pwu_pa_fault_i),
        .pwu_pa_rdy_o   (pwu_pa_rdy_o),
        .inflight_o     (inflight_o),
        .orphan_err_o   (orphan_err_o)
    );

    // Reference state: queue of requester ids in flight, issue slot, pointer, sticky flag.
    int          tagq[$];
    bit          m_iss_vld;
    logic [31:0] m_iss_va;
    int          m_rr;
    bit          m_orphan;

    bit          e_grant;
    int          e_g;
    logic [3:0]  e_req_rdy;
    logic [3:0]  e_resp_vld;
    bit          e_pa_rdy;

    int n_chk;
    int n_fail;
    logic [31:0] saved_va;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic eval();
        bit can;
        bit nonempty;
        int r;
        #1;
        can = (!m_iss_vld || pwu_va_rdy_i) && (tagq.size() < D) && !reset_i;
        e_grant = 1'b0;
        e_g = 0;
        for (int k = 0; k < NR; k++) begin
            r = (m_rr + k) % NR;
            if (!e_grant && req_vld_i[r]) begin
                e_grant = 1'b1;
                e_g = r;
            end
        end
        e_grant   = e_grant && can;
        e_req_rdy = e_grant ? (4'b0001 << e_g) : 4'b0000;
        nonempty  = (tagq.size() != 0);
        e_resp_vld = 4'b0000;
        e_pa_rdy   = 1'b0;
        if (nonempty && !reset_i) begin
            e_resp_vld = pwu_pa_vld_i ? (4'b0001 << tagq[0]) : 4'b0000;
            e_pa_rdy   = resp_rdy_i[tagq[0]];
        end
        check("req_rdy", req_rdy_o, e_req_rdy);
        check("resp_vld", resp_vld_o, e_resp_vld);
        check("pa_rdy", pwu_pa_rdy_o, e_pa_rdy);
        check("va_vld", pwu_va_vld_o, m_iss_vld);
        if (m_iss_vld) check("va", pwu_va_o, m_iss_va);
        check("inflight", inflight_o, tagq.size());
        check("orphan", orphan_err_o, m_orphan);
        check("resp_pa", resp_pa_o, pwu_pa_i);
        check("resp_fault", resp_fault_o, pwu_pa_fault_i);
    endtask

    task automatic advance();
        @(posedge clk);
        if (reset_i) begin
            tagq.delete();
            m_iss_vld = 1'b0;
            m_iss_va  = '0;
            m_rr      = 0;
            m_orphan  = 1'b0;
        end else begin
            if (pwu_pa_vld_i && tagq.size() == 0) m_orphan = 1'b1;
            if (pwu_pa_vld_i && e_pa_rdy) void'(tagq.pop_front());
            if (e_grant) begin
                tagq.push_back(e_g);
                m_iss_vld = 1'b1;
                m_iss_va  = req_va_i[e_g*VW +: VW];
                m_rr      = (e_g + 1) % NR;
            end else if (pwu_va_rdy_i) begin
                m_iss_vld = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic step();
        eval();
        advance();
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        reset_i = 1'b1;
        req_va_i = '0;
        req_vld_i = 4'hF;
        resp_rdy_i = 4'hF;
        pwu_va_rdy_i = 1'b1;
        pwu_pa_i = '0;
        pwu_pa_vld_i = 1'b0;
        pwu_pa_fault_i = 1'b0;
        repeat (2) @(posedge clk);
        tagq.delete();
        m_iss_vld = 1'b0;
        m_iss_va = '0;
        m_rr = 0;
        m_orphan = 1'b0;
        @(negedge clk);

        // Reset state, requests held valid.
        eval();
        check("rst_req_rdy", req_rdy_o, 4'b0000);
        check("rst_inflight", inflight_o, 0);
        check("rst_va_vld", pwu_va_vld_o, 0);
        check("rst_orphan", orphan_err_o, 0);
        advance();
        reset_i = 1'b0;

        // Single request from requester 2.
        req_vld_i = 4'b0100;
        req_va_i[2*VW +: VW] = 32'h1234_5000;
        eval();
        check("t1_rdy", req_rdy_o, 4'b0100);
        advance();
        req_vld_i = 4'b0000;
        eval();
        check("t1_va_vld", pwu_va_vld_o, 1);
        check("t1_va", pwu_va_o, 32'h1234_5000);
        check("t1_inflight1", inflight_o, 1);
        advance();
        step();
        pwu_pa_vld_i = 1'b1;
        pwu_pa_i = 28'hABC_D000;
        eval();
        check("t1_resp_vld", resp_vld_o, 4'b0100);
        check("t1_resp_pa", resp_pa_o, 28'hABC_D000);
        check("t1_pa_rdy", pwu_pa_rdy_o, 1);
        advance();
        pwu_pa_vld_i = 1'b0;
        eval();
        check("t1_inflight0", inflight_o, 0);
        advance();

        // Fairness and full backpressure.
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        req_vld_i = 4'hF;
        req_va_i = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 8; i++) begin
            eval();
            check("fair_gnt", req_rdy_o, 64'(1) << (i % 4));
            advance();
        end
        eval();
        check("full_rdy", req_rdy_o, 0);
        check("full_inflight", inflight_o, 8);
        advance();
        pwu_pa_vld_i = 1'b1;
        eval();
        check("full_pop_same", req_rdy_o, 0);
        check("full_pop_resp", resp_vld_o, 4'b0001);
        advance();
        pwu_pa_vld_i = 1'b0;
        eval();
        check("full_next_gnt", req_rdy_o, 4'b0001);
        check("full_next_inflight", inflight_o, 7);
        advance();
        req_vld_i = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            pwu_pa_vld_i = 1'b1;
            eval();
            check("fair_resp", resp_vld_o, 64'(1) << (k % 4));
            advance();
        end
        pwu_pa_vld_i = 1'b0;
        eval();
        check("drain_inflight", inflight_o, 0);
        advance();

        // Issue stall: register loaded, PWU not ready for five cycles.
        pwu_va_rdy_i = 1'b0;
        req_vld_i = 4'hF;
        req_va_i = {$urandom, $urandom, $urandom, $urandom};
        saved_va = req_va_i[1*VW +: VW];
        eval();
        check("stall_gnt", req_rdy_o, 4'b0010);
        advance();
        for (int i = 0; i < 5; i++) begin
            req_va_i = {$urandom, $urandom, $urandom, $urandom};
            eval();
            check("stall_rdy", req_rdy_o, 0);
            check("stall_va", pwu_va_o, saved_va);
            advance();
        end
        pwu_va_rdy_i = 1'b1;
        eval();
        check("stall_release_gnt", req_rdy_o, 4'b0100);
        advance();
        req_vld_i = 4'b0000;
        pwu_pa_vld_i = 1'b1;
        repeat (2) step();
        pwu_pa_vld_i = 1'b0;

        // Response stall on requester 1 with a faulted PA.
        req_vld_i = 4'b0010;
        step();
        req_vld_i = 4'b0000;
        step();
        pwu_pa_vld_i = 1'b1;
        pwu_pa_fault_i = 1'b1;
        pwu_pa_i = 28'($urandom);
        resp_rdy_i = 4'b1101;
        for (int i = 0; i < 3; i++) begin
            eval();
            check("rstall_pa_rdy", pwu_pa_rdy_o, 0);
            check("rstall_resp_vld", resp_vld_o, 4'b0010);
            check("rstall_inflight", inflight_o, 1);
            advance();
        end
        resp_rdy_i = 4'hF;
        eval();
        check("rstall_go", pwu_pa_rdy_o, 1);
        check("rstall_fault", resp_fault_o, 1);
        advance();
        pwu_pa_vld_i = 1'b0;
        pwu_pa_fault_i = 1'b0;
        eval();
        check("rstall_done", inflight_o, 0);
        advance();

        // Orphan response.
        pwu_pa_vld_i = 1'b1;
        eval();
        check("orph_pa_rdy", pwu_pa_rdy_o, 0);
        check("orph_resp_vld", resp_vld_o, 0);
        advance();
        pwu_pa_vld_i = 1'b0;
        eval();
        check("orph_set", orphan_err_o, 1);
        advance();

        // Reset with five in flight.
        req_vld_i = 4'hF;
        repeat (5) step();
        req_vld_i = 4'b0000;
        reset_i = 1'b1;
        eval();
        check("mid_inflight5", inflight_o, 5);
        advance();
        reset_i = 1'b0;
        req_vld_i = 4'hF;
        eval();
        check("mid_inflight0", inflight_o, 0);
        check("mid_va_vld", pwu_va_vld_o, 0);
        check("mid_orphan", orphan_err_o, 0);
        check("mid_rr0", req_rdy_o, 4'b0001);
        advance();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            reset_i        = ($urandom_range(0, 149) == 0);
            req_vld_i      = 4'($urandom);
            req_va_i       = {$urandom, $urandom, $urandom, $urandom};
            resp_rdy_i     = 4'($urandom) | 4'($urandom);
            pwu_va_rdy_i   = ($urandom_range(0, 3) != 0);
            pwu_pa_vld_i   = ($urandom_range(0, 9) < 4);
            pwu_pa_fault_i = 1'($urandom);
            pwu_pa_i       = 28'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
